// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving every datapath enable.
// One control step per clock; outputs are decoded from the state register, IR and CON.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Cout,
    output logic        CONin,
    output logic        OutportIn,
    output logic        InPortOut,
    output logic        Read,
    output logic        Write,
    output logic        MBIout,
    output logic [4:0]  OpCode,
    output logic        Run,
    output logic [4:0]  Step
);

    typedef enum logic [4:0] {
        S_RESET = 5'd0,
        S_T0    = 5'd1,
        S_T1    = 5'd2,
        S_T2    = 5'd3,
        S_T3    = 5'd4,
        S_T4    = 5'd5,
        S_T5    = 5'd6,
        S_T6    = 5'd7,
        S_T7    = 5'd8,
        S_HALT  = 5'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BRX  = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11010;
    localparam logic [4:0] OP_INC  = 5'b11011;

    state_t     state_r;
    state_t     next_s;
    logic [4:0] op_s;
    logic       is_rr_s;
    logic       is_imm_s;
    logic       is_ldst_s;
    logic       is_negnot_s;
    logic       is_muldiv_s;
    logic [4:0] imm_op_s;
    logic       unused_ir_s;

    assign op_s        = IR[31:27];
    assign unused_ir_s = ^IR[26:0];

    // Opcode class decode shared by next-state and output logic
    always_comb begin
        is_rr_s     = (op_s >= OP_ADD) && (op_s <= OP_OR);
        is_imm_s    = (op_s == OP_ADDI) || (op_s == OP_ANDI) || (op_s == OP_ORI);
        is_ldst_s   = (op_s == OP_LD) || (op_s == OP_LDI) || (op_s == OP_ST);
        is_negnot_s = (op_s == OP_NEG) || (op_s == OP_NOT);
        is_muldiv_s = (op_s == OP_MUL) || (op_s == OP_DIV);
        if (op_s == OP_ANDI) begin
            imm_op_s = OP_AND;
        end else if (op_s == OP_ORI) begin
            imm_op_s = OP_OR;
        end else begin
            imm_op_s = OP_ADD;
        end
    end

    // State register, cleared asynchronously by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= S_RESET;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state: each instruction leaves its last step back to T0
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_RESET: next_s = S_T0;
            S_T0:    next_s = S_T1;
            S_T1:    next_s = S_T2;
            S_T2:    next_s = S_T3;
            S_T3: begin
                if (op_s == OP_HALT) begin
                    next_s = S_HALT;
                end else if (is_rr_s || is_imm_s || is_ldst_s || is_negnot_s || is_muldiv_s
                             || (op_s == OP_BRX) || (op_s == OP_JAL)) begin
                    next_s = S_T4;
                end else begin
                    next_s = S_T0;
                end
            end
            S_T4:    next_s = (is_negnot_s || (op_s == OP_JAL)) ? S_T0 : S_T5;
            S_T5:    next_s = (is_rr_s || is_imm_s || (op_s == OP_LDI)) ? S_T0 : S_T6;
            S_T6:    next_s = (is_muldiv_s || (op_s == OP_BRX)) ? S_T0 : S_T7;
            S_T7:    next_s = S_T0;
            S_HALT:  next_s = S_HALT;
            default: next_s = S_RESET;
        endcase
    end

    assign MBIout = 1'b0;
    assign Step   = state_r;
    assign Run    = (state_r != S_RESET) && (state_r != S_HALT);

    // Control step decode: everything defaults low, each step raises its enables
    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout}                          = 6'b000000;
        {PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout, MARin}    = 8'h00;
        {MDRin, MDRout, HIin, HIout, LOin, LOout, Cout, CONin}     = 8'h00;
        {OutportIn, InPortOut, Read, Write}                        = 4'h0;
        OpCode = 5'b00000;
        case (state_r)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = OP_INC; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_rr_s || is_imm_s) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_ldst_s) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_negnot_s) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = op_s;
                end else if (is_muldiv_s) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else begin
                    case (op_s)
                        OP_BRX:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                        OP_IN:   begin InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1; end
                        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: OpCode = 5'b00000;
                    endcase
                end
            end
            S_T4: begin
                if (is_rr_s) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = op_s;
                end else if (is_imm_s) begin
                    Cout = 1'b1; Zin = 1'b1; OpCode = imm_op_s;
                end else if (is_ldst_s) begin
                    Cout = 1'b1; Zin = 1'b1; OpCode = OP_ADD;
                end else if (is_negnot_s) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv_s) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = op_s;
                end else if (op_s == OP_BRX) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (op_s == OP_JAL) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else begin
                    OpCode = 5'b00000;
                end
            end
            S_T5: begin
                if (is_rr_s || is_imm_s || (op_s == OP_LDI)) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if ((op_s == OP_LD) || (op_s == OP_ST)) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_muldiv_s) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (op_s == OP_BRX) begin
                    Cout = 1'b1; Zin = 1'b1; OpCode = OP_ADD;
                end else begin
                    OpCode = 5'b00000;
                end
            end
            S_T6: begin
                if (op_s == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (op_s == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_muldiv_s) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end else if ((op_s == OP_BRX) && CON) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end else begin
                    OpCode = 5'b00000;
                end
            end
            S_T7: begin
                if (op_s == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_s == OP_ST) begin
                    Write = 1'b1; MDRout = 1'b1;
                end else begin
                    OpCode = 5'b00000;
                end
            end
            default: OpCode = 5'b00000;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each instruction pushes its expected per-step
// control words, which are popped and compared one per clock.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR  = 32'h0;
    logic        CON = 1'b0;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCin, PCout, IRin, Yin, Zin, Zhighout, Zlowout;
    logic MARin, MDRin, MDRout, HIin, HIout, LOin, LOout, Cout, CONin, OutportIn, InPortOut;
    logic Read, Write, MBIout, Run;
    logic [4:0] OpCode, Step;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Cout(Cout), .CONin(CONin), .OutportIn(OutportIn), .InPortOut(InPortOut),
        .Read(Read), .Write(Write), .MBIout(MBIout), .OpCode(OpCode), .Run(Run), .Step(Step)
    );

    always #5 clk = ~clk;

    localparam logic [26:0] M_GRA  = 27'd1 << 0,  M_GRB  = 27'd1 << 1,  M_GRC  = 27'd1 << 2;
    localparam logic [26:0] M_RIN  = 27'd1 << 3,  M_ROUT = 27'd1 << 4,  M_BA   = 27'd1 << 5;
    localparam logic [26:0] M_PCIN = 27'd1 << 6,  M_PCO  = 27'd1 << 7,  M_IRIN = 27'd1 << 8;
    localparam logic [26:0] M_YIN  = 27'd1 << 9,  M_ZIN  = 27'd1 << 10, M_ZHI  = 27'd1 << 11;
    localparam logic [26:0] M_ZLO  = 27'd1 << 12, M_MAR  = 27'd1 << 13, M_MDRI = 27'd1 << 14;
    localparam logic [26:0] M_MDRO = 27'd1 << 15, M_HIIN = 27'd1 << 16, M_HIO  = 27'd1 << 17;
    localparam logic [26:0] M_LOIN = 27'd1 << 18, M_LOO  = 27'd1 << 19, M_COUT = 27'd1 << 20;
    localparam logic [26:0] M_CONI = 27'd1 << 21, M_OUTP = 27'd1 << 22, M_INP  = 27'd1 << 23;
    localparam logic [26:0] M_RD   = 27'd1 << 24, M_WR   = 27'd1 << 25;

    typedef struct packed {
        logic        run;
        logic [4:0]  step;
        logic [4:0]  opc;
        logic [26:0] ctl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [26:0] ctl_obs_s;
    exp_t        obs_s;
    assign ctl_obs_s = {MBIout, Write, Read, InPortOut, OutportIn, CONin, Cout, LOout, LOin,
                        HIout, HIin, MDRout, MDRin, MARin, Zlowout, Zhighout, Zin, Yin, IRin,
                        PCout, PCin, BAout, Rout, Rin, Grc, Grb, Gra};
    assign obs_s = '{run: Run, step: Step, opc: OpCode, ctl: ctl_obs_s};

    task automatic check_eq(input string tag, input logic [37:0] got, input logic [37:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Push one expected step: t is the T-number (T0 -> Step 1)
    task automatic e(input int t, input logic [26:0] c, input logic [4:0] o);
        q.push_back('{run: 1'b1, step: 5'(t + 1), opc: o, ctl: c});
    endtask

    task automatic push_instr(input logic [4:0] op, input logic con);
        e(0, M_PCO | M_MAR | M_ZIN, 5'b11011);
        e(1, M_ZLO | M_PCIN | M_RD | M_MDRI, 5'd0);
        e(2, M_MDRO | M_IRIN, 5'd0);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
                e(3, M_GRB | M_ROUT | M_YIN, 5'd0);
                e(4, M_GRC | M_ROUT | M_ZIN, op);
                e(5, M_ZLO | M_GRA | M_RIN, 5'd0);
            end
            5'd11, 5'd12, 5'd13: begin
                e(3, M_GRB | M_ROUT | M_YIN, 5'd0);
                e(4, M_COUT | M_ZIN, (op == 5'd11) ? 5'b00011 : (op == 5'd12) ? 5'b01001 : 5'b01010);
                e(5, M_ZLO | M_GRA | M_RIN, 5'd0);
            end
            5'd16, 5'd17: begin
                e(3, M_GRB | M_ROUT | M_ZIN, op);
                e(4, M_ZLO | M_GRA | M_RIN, 5'd0);
            end
            5'd14, 5'd15: begin
                e(3, M_GRA | M_ROUT | M_YIN, 5'd0);
                e(4, M_GRB | M_ROUT | M_ZIN, op);
                e(5, M_ZLO | M_LOIN, 5'd0);
                e(6, M_ZHI | M_HIIN, 5'd0);
            end
            5'd0, 5'd1, 5'd2: begin
                e(3, M_GRB | M_BA | M_YIN, 5'd0);
                e(4, M_COUT | M_ZIN, 5'b00011);
                if (op == 5'd1) begin
                    e(5, M_ZLO | M_GRA | M_RIN, 5'd0);
                end else if (op == 5'd0) begin
                    e(5, M_ZLO | M_MAR, 5'd0);
                    e(6, M_RD | M_MDRI, 5'd0);
                    e(7, M_MDRO | M_GRA | M_RIN, 5'd0);
                end else begin
                    e(5, M_ZLO | M_MAR, 5'd0);
                    e(6, M_GRA | M_ROUT | M_MDRI, 5'd0);
                    e(7, M_WR | M_MDRO, 5'd0);
                end
            end
            5'd18: begin
                e(3, M_GRA | M_ROUT | M_CONI, 5'd0);
                e(4, M_PCO | M_YIN, 5'd0);
                e(5, M_COUT | M_ZIN, 5'b00011);
                e(6, con ? (M_ZLO | M_PCIN) : 27'd0, 5'd0);
            end
            5'd19: e(3, M_GRA | M_ROUT | M_PCIN, 5'd0);
            5'd20: begin
                e(3, M_PCO | M_GRB | M_RIN, 5'd0);
                e(4, M_GRA | M_ROUT | M_PCIN, 5'd0);
            end
            5'd21: e(3, M_INP | M_GRA | M_RIN, 5'd0);
            5'd22: e(3, M_GRA | M_ROUT | M_OUTP, 5'd0);
            5'd23: e(3, M_HIO | M_GRA | M_RIN, 5'd0);
            5'd24: e(3, M_LOO | M_GRA | M_RIN, 5'd0);
            5'd26: begin
                e(3, 27'd0, 5'd0);
                for (int i = 0; i < 10; i++) q.push_back('{run: 1'b0, step: 5'd9, opc: 5'd0, ctl: 27'd0});
            end
            default: e(3, 27'd0, 5'd0);
        endcase
    endtask

    // Pop and compare one expected word per clock; IR/CON are applied during T0
    task automatic drain(input string tag, input logic [31:0] ir, input logic con);
        bit first = 1'b1;
        exp_t x;
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            if (first) begin
                IR = ir;
                CON = con;
                first = 1'b0;
                #1;
            end
            x = q.pop_front();
            check_eq($sformatf("%s_step%0d", tag, x.step), obs_s, x);
            check_eq($sformatf("%s_rdwr", tag), {37'd0, Read & Write}, 38'd0);
        end
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ir, input logic con);
        push_instr(ir[31:27], con);
        drain(tag, ir, con);
    endtask

    // Run an instruction only up to step T<n>, then pulse clr mid-instruction
    task automatic abort_at(input string tag, input logic [31:0] ir, input int t);
        push_instr(ir[31:27], 1'b0);
        while (q.size() > t + 1) void'(q.pop_back());
        drain(tag, ir, 1'b0);
        #1 clr = 1'b1;
        #1 check_eq({tag, "_clr"}, obs_s, 38'd0);
        @(negedge clk);
        check_eq({tag, "_held"}, obs_s, 38'd0);
        clr = 1'b0;
    endtask

    initial begin
        #12;
        check_eq("reset_hold", obs_s, 38'd0);
        @(negedge clk);
        clr = 1'b0;
        #1 check_eq("reset_release", obs_s, 38'd0);
        run_instr("add",    32'h18918000, 1'b0);
        run_instr("ld",     32'h00900065, 1'b0);
        run_instr("ldi",    32'h08900065, 1'b0);
        run_instr("brx_t",  32'h90800000, 1'b1);
        run_instr("brx_nt", 32'h90800000, 1'b0);
        run_instr("st",     32'h10900065, 1'b0);
        run_instr("mul",    32'h70980000, 1'b0);
        run_instr("div",    32'h78980000, 1'b0);
        run_instr("neg",    32'h80900000, 1'b0);
        run_instr("not",    32'h88900000, 1'b0);
        run_instr("addi",   32'h58900007, 1'b0);
        run_instr("andi",   32'h60900007, 1'b0);
        run_instr("ori",    32'h68900007, 1'b0);
        run_instr("jr",     32'h98800000, 1'b0);
        run_instr("jal",    32'hA0900000, 1'b0);
        run_instr("in",     32'hA8800000, 1'b0);
        run_instr("out",    32'hB0800000, 1'b0);
        run_instr("mfhi",   32'hB8800000, 1'b0);
        run_instr("mflo",   32'hC0800000, 1'b0);
        run_instr("nop",    32'hC8000000, 1'b0);
        run_instr("unasg",  32'hF8000000, 1'b0);
        run_instr("halt",   32'hD0000000, 1'b0);
        #1 clr = 1'b1;
        #1 check_eq("halt_clr", obs_s, 38'd0);
        @(negedge clk);
        clr = 1'b0;
        abort_at("add_abort", 32'h18918000, 4);
        abort_at("st_abort", 32'h10900065, 7);
        run_instr("add_again", 32'h18918000, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
